dmem_arbiter: RTL and testbench

Shares the single vector data memory (`data_mem_vect`) between the pipeline's MEM stage and a host loader port that preloads RSA operands and reads back results. The CPU always gets priority, but bounded starvation guarantees host progress; a lock mode grants the host burst ownership. The block sits between `segment_ex_mem` outputs and `data_mem_vect`, and drives a stall into the pipeline segment registers.

---
 rtl/rsa_pkg.sv | 20 ++
 rtl/dmem_arbiter_sat_counter.sv | 28 ++
 rtl/dmem_arbiter.sv | 150 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types and default sizes for the RSA vector datapath.
package rsa_pkg;

  localparam int DEF_I = 32;
  localparam int DEF_N = 8;
  localparam int DEF_R = 6;

  typedef logic [DEF_R-1:0][DEF_N-1:0] vec_t;

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Bits needed to hold a counter value in the range 0..maxVal.
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
  import rsa_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int MAX   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);

  // Count up to MaxVal and stick there until cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MaxVal)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the vector data memory between the MEM stage and the host loader.
// The CPU normally wins; starveCnt forces a host slot after STARVE_MAX losses,
// and a locked host burst is cut after BURST_MAX cycles to give the CPU a slot.
module dmem_arbiter
  import rsa_pkg::*;
#(
  parameter int I          = DEF_I,
  parameter int N          = DEF_N,
  parameter int R          = DEF_R,
  parameter int STARVE_MAX = 4,
  parameter int BURST_MAX  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                CpuReqM,
  input  logic                CpuWeM,
  input  logic [I-1:0]        CpuAM,
  input  logic [R-1:0][N-1:0] CpuWDM,
  output logic [R-1:0][N-1:0] CpuRD,
  output logic                CpuStall,
  input  logic                HostReq,
  input  logic                HostWe,
  input  logic                HostLock,
  input  logic [I-1:0]        HostA,
  input  logic [R-1:0][N-1:0] HostWD,
  output logic                HostGnt,
  output logic                HostRDValid,
  output logic [R-1:0][N-1:0] HostRD,
  output logic                MemWE,
  output logic [I-1:0]        MemA,
  output logic [R-1:0][N-1:0] MemWD,
  input  logic [R-1:0][N-1:0] MemRD
);

  localparam int StarveW = cntWidth(STARVE_MAX);
  localparam int BurstW  = cntWidth(BURST_MAX);
  localparam logic [StarveW-1:0] StarveTop = StarveW'(STARVE_MAX);
  localparam logic [BurstW-1:0]  BurstTop  = BurstW'(BURST_MAX);

  arb_state_t          state;
  arb_state_t          nextState;
  logic [StarveW-1:0]  starveCnt;
  logic [BurstW-1:0]   burstCnt;
  logic                cpuGnt;
  logic                hostGnt;
  logic                stall;
  logic                starveInc;
  logic                starveClr;
  logic                burstInc;
  logic                burstClr;

  sat_counter #(
    .WIDTH (StarveW),
    .MAX   (STARVE_MAX)
  ) starveCounter (
    .clk   (clk),
    .reset (reset),
    .inc   (starveInc),
    .clr   (starveClr),
    .count (starveCnt)
  );

  sat_counter #(
    .WIDTH (BurstW),
    .MAX   (BURST_MAX)
  ) burstCounter (
    .clk   (clk),
    .reset (reset),
    .inc   (burstInc),
    .clr   (burstClr),
    .count (burstCnt)
  );

  // Per-cycle grant decision; everything is forced idle while reset is held low.
  always_comb begin
    cpuGnt    = 1'b0;
    hostGnt   = 1'b0;
    stall     = 1'b0;
    starveInc = 1'b0;
    starveClr = 1'b0;
    burstInc  = 1'b0;
    burstClr  = 1'b0;
    nextState = state;
    if (reset) begin
      case (state)
        ARB: begin
          if (CpuReqM && HostReq) begin
            if (starveCnt == StarveTop) begin
              hostGnt = 1'b1;
              stall   = 1'b1;
            end else begin
              cpuGnt    = 1'b1;
              starveInc = 1'b1;
            end
          end else if (CpuReqM) begin
            cpuGnt = 1'b1;
          end else if (HostReq) begin
            hostGnt = 1'b1;
          end
          if (hostGnt && HostLock) begin
            burstInc  = 1'b1;
            nextState = BURST;
          end
        end
        BURST: begin
          if (burstCnt == BurstTop) begin
            cpuGnt    = CpuReqM;
            burstClr  = 1'b1;
            nextState = ARB;
          end else begin
            hostGnt  = HostReq;
            stall    = CpuReqM;
            burstInc = HostReq;
            if (!HostReq || !HostLock) begin
              burstClr  = 1'b1;
              nextState = ARB;
            end
          end
        end
        default: begin
          nextState = ARB;
        end
      endcase
      starveClr = hostGnt;
    end
  end

  // State register and the registered host read-back path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ARB;
      HostRDValid <= 1'b0;
      HostRD      <= '0;
    end else begin
      state       <= nextState;
      HostRDValid <= hostGnt && !HostWe;
      if (hostGnt && !HostWe) begin
        HostRD <= MemRD;
      end
    end
  end

  assign MemA     = hostGnt ? HostA  : CpuAM;
  assign MemWD    = hostGnt ? HostWD : CpuWDM;
  assign MemWE    = (cpuGnt && CpuWeM) || (hostGnt && HostWe);
  assign CpuRD    = MemRD;
  assign CpuStall = stall;
  assign HostGnt  = hostGnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a simple behavioural data memory.
module tb_dmem_arbiter;
  import rsa_pkg::*;

  logic        clk;
  logic        reset;
  logic        CpuReqM;
  logic        CpuWeM;
  logic [31:0] CpuAM;
  vec_t        CpuWDM;
  vec_t        CpuRD;
  logic        CpuStall;
  logic        HostReq;
  logic        HostWe;
  logic        HostLock;
  logic [31:0] HostA;
  vec_t        HostWD;
  logic        HostGnt;
  logic        HostRDValid;
  vec_t        HostRD;
  logic        MemWE;
  logic [31:0] MemA;
  vec_t        MemWD;
  vec_t        MemRD;

  vec_t        mem [0:255];
  int          errors = 0;
  int          checks = 0;

  dmem_arbiter #(
    .I          (32),
    .N          (8),
    .R          (6),
    .STARVE_MAX (4),
    .BURST_MAX  (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .CpuReqM     (CpuReqM),
    .CpuWeM      (CpuWeM),
    .CpuAM       (CpuAM),
    .CpuWDM      (CpuWDM),
    .CpuRD       (CpuRD),
    .CpuStall    (CpuStall),
    .HostReq     (HostReq),
    .HostWe      (HostWe),
    .HostLock    (HostLock),
    .HostA       (HostA),
    .HostWD      (HostWD),
    .HostGnt     (HostGnt),
    .HostRDValid (HostRDValid),
    .HostRD      (HostRD),
    .MemWE       (MemWE),
    .MemA        (MemA),
    .MemWD       (MemWD),
    .MemRD       (MemRD)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural data_mem_vect: combinational read, write on the rising edge.
  always @(posedge clk) begin
    if (MemWE) mem[MemA[7:0]] <= MemWD;
  end
  assign MemRD = mem[MemA[7:0]];

  function automatic vec_t fillVec(input logic [7:0] b);
    vec_t v;
    for (int i = 0; i < 6; i++) v[i] = b;
    return v;
  endfunction

  function automatic vec_t laneVec();
    vec_t v;
    for (int i = 0; i < 6; i++) v[i] = 8'(i + 1);
    return v;
  endfunction

  task automatic applyStimulus(input logic cReq, input logic cWe, input logic [31:0] cA,
                               input vec_t cWd, input logic hReq, input logic hWe,
                               input logic hLock, input logic [31:0] hA, input vec_t hWd);
    CpuReqM  = cReq;
    CpuWeM   = cWe;
    CpuAM    = cA;
    CpuWDM   = cWd;
    HostReq  = hReq;
    HostWe   = hWe;
    HostLock = hLock;
    HostA    = hA;
    HostWD   = hWd;
  endtask

  task automatic goIdle();
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b0, 32'h0, '0);
  endtask

  // Reset held low: arbitration outputs and host read regs are forced off.
  task automatic test_reset();
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'h10, fillVec(8'h55), 1'b1, 1'b1, 1'b1, 32'h20, fillVec(8'h66));
    #1;
    checks++; if (MemWE !== 1'b0) begin errors++; $display("[TB] FAIL reset_memwe: got %b want 0", MemWE); end
    checks++; if (HostGnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_hostgnt: got %b want 0", HostGnt); end
    checks++; if (CpuStall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b want 0", CpuStall); end
    @(posedge clk); #1;
    checks++; if (HostRDValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rdvalid: got %b want 0", HostRDValid); end
    checks++; if (HostRD !== '0) begin errors++; $display("[TB] FAIL reset_hostrd: got %h want 0", HostRD); end
    goIdle();
    reset = 1'b1;
  endtask

  // CPU store then load at 0x10 with no host traffic.
  task automatic test_cpu_store_load();
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 32'h10, laneVec(), 1'b0, 1'b0, 1'b0, 32'h0, '0);
    #1;
    checks++; if (MemWE !== 1'b1) begin errors++; $display("[TB] FAIL cpu_store_we: got %b want 1", MemWE); end
    checks++; if (MemA !== 32'h10) begin errors++; $display("[TB] FAIL cpu_store_addr: got %h want 10", MemA); end
    checks++; if (MemWD !== laneVec()) begin errors++; $display("[TB] FAIL cpu_store_wd: got %h want %h", MemWD, laneVec()); end
    checks++; if (CpuStall !== 1'b0) begin errors++; $display("[TB] FAIL cpu_store_stall: got %b want 0", CpuStall); end
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h10, '0, 1'b0, 1'b0, 1'b0, 32'h0, '0);
    #1;
    checks++; if (CpuRD !== laneVec()) begin errors++; $display("[TB] FAIL cpu_load_rd: got %h want %h", CpuRD, laneVec()); end
    checks++; if (MemWE !== 1'b0) begin errors++; $display("[TB] FAIL cpu_load_we: got %b want 0", MemWE); end
    checks++; if (CpuStall !== 1'b0) begin errors++; $display("[TB] FAIL cpu_load_stall: got %b want 0", CpuStall); end
    goIdle();
  endtask

  // Host write 0x20 = 0xAA..., then read it back one cycle after the grant.
  task automatic test_host_write_read();
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, '0, 1'b1, 1'b1, 1'b0, 32'h20, fillVec(8'hAA));
    #1;
    checks++; if (HostGnt !== 1'b1) begin errors++; $display("[TB] FAIL host_wr_gnt: got %b want 1", HostGnt); end
    checks++; if (MemWE !== 1'b1) begin errors++; $display("[TB] FAIL host_wr_we: got %b want 1", MemWE); end
    checks++; if (MemA !== 32'h20) begin errors++; $display("[TB] FAIL host_wr_addr: got %h want 20", MemA); end
    @(negedge clk);
    checks++; if (HostRDValid !== 1'b0) begin errors++; $display("[TB] FAIL host_wr_novalid: got %b want 0", HostRDValid); end
    applyStimulus(1'b0, 1'b0, 32'h0, '0, 1'b1, 1'b0, 1'b0, 32'h20, '0);
    #1;
    checks++; if (HostGnt !== 1'b1) begin errors++; $display("[TB] FAIL host_rd_gnt: got %b want 1", HostGnt); end
    checks++; if (MemWE !== 1'b0) begin errors++; $display("[TB] FAIL host_rd_we: got %b want 0", MemWE); end
    goIdle();
    #1;
    checks++; if (HostRDValid !== 1'b1) begin errors++; $display("[TB] FAIL host_rd_valid: got %b want 1", HostRDValid); end
    checks++; if (HostRD !== fillVec(8'hAA)) begin errors++; $display("[TB] FAIL host_rd_data: got %h want %h", HostRD, fillVec(8'hAA)); end
    @(negedge clk); #1;
    checks++; if (HostRDValid !== 1'b0) begin errors++; $display("[TB] FAIL host_rd_validdrop: got %b want 0", HostRDValid); end
    checks++; if (HostRD !== fillVec(8'hAA)) begin errors++; $display("[TB] FAIL host_rd_hold: got %h want %h", HostRD, fillVec(8'hAA)); end
  endtask

  // Continuous contention: four CPU wins, then one forced host slot, repeating.
  task automatic test_starvation();
    logic expHost;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 32'h10, '0, 1'b1, 1'b0, 1'b0, 32'h20, '0);
      #1;
      expHost = (c == 4) || (c == 9);
      checks++; if (HostGnt !== expHost) begin errors++; $display("[TB] FAIL starve_gnt[%0d]: got %b want %b", c, HostGnt, expHost); end
      checks++; if (CpuStall !== expHost) begin errors++; $display("[TB] FAIL starve_stall[%0d]: got %b want %b", c, CpuStall, expHost); end
      checks++; if (MemA !== (expHost ? 32'h20 : 32'h10)) begin errors++; $display("[TB] FAIL starve_addr[%0d]: got %h want %h", c, MemA, (expHost ? 32'h20 : 32'h10)); end
    end
    goIdle();
    #1;
    checks++; if (HostRDValid !== 1'b1) begin errors++; $display("[TB] FAIL starve_rdvalid: got %b want 1", HostRDValid); end
    checks++; if (HostRD !== fillVec(8'hAA)) begin errors++; $display("[TB] FAIL starve_rddata: got %h want %h", HostRD, fillVec(8'hAA)); end
  endtask

  // Locked host burst of 12 writes against a requesting CPU.
  task automatic test_burst();
    int   k;
    logic expGnt;
    logic expStall;
    k = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      applyStimulus(c <= 12, 1'b0, 32'h10, '0, k < 12, 1'b1, k < 12,
                    32'(32'h40 + k), fillVec(8'(k)));
      #1;
      expGnt   = (c >= 4 && c <= 11) || (c >= 13 && c <= 16);
      expStall = (c >= 4 && c <= 11);
      checks++; if (HostGnt !== expGnt) begin errors++; $display("[TB] FAIL burst_gnt[%0d]: got %b want %b", c, HostGnt, expGnt); end
      checks++; if (CpuStall !== expStall) begin errors++; $display("[TB] FAIL burst_stall[%0d]: got %b want %b", c, CpuStall, expStall); end
      if (c == 12) begin
        checks++; if (MemA !== 32'h10) begin errors++; $display("[TB] FAIL burst_cpuslot_addr: got %h want 10", MemA); end
      end
      if (HostGnt) k++;
    end
    goIdle();
    checks++; if (k !== 12) begin errors++; $display("[TB] FAIL burst_count: got %0d want 12", k); end
    checks++; if (mem[8'h4B] !== fillVec(8'd11)) begin errors++; $display("[TB] FAIL burst_lastword: got %h want %h", mem[8'h4B], fillVec(8'd11)); end
  endtask

  // Reset in the middle of a burst aborts it; the next access is arbitrated in ARB.
  task automatic test_reset_mid_burst();
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, '0, 1'b1, 1'b1, 1'b1, 32'h50, fillVec(8'h01));
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, '0, 1'b1, 1'b1, 1'b1, 32'h51, fillVec(8'h02));
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, '0, 1'b1, 1'b0, 1'b1, 32'h20, '0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h10, '0, 1'b1, 1'b1, 1'b1, 32'h52, fillVec(8'h03));
    #1;
    checks++; if (HostGnt !== 1'b1) begin errors++; $display("[TB] FAIL midburst_gnt: got %b want 1", HostGnt); end
    checks++; if (CpuStall !== 1'b1) begin errors++; $display("[TB] FAIL midburst_stall: got %b want 1", CpuStall); end
    checks++; if (HostRDValid !== 1'b1) begin errors++; $display("[TB] FAIL midburst_rdvalid: got %b want 1", HostRDValid); end
    #1 reset = 1'b0;
    #1;
    checks++; if (MemWE !== 1'b0) begin errors++; $display("[TB] FAIL rstburst_we: got %b want 0", MemWE); end
    checks++; if (HostGnt !== 1'b0) begin errors++; $display("[TB] FAIL rstburst_gnt: got %b want 0", HostGnt); end
    checks++; if (CpuStall !== 1'b0) begin errors++; $display("[TB] FAIL rstburst_stall: got %b want 0", CpuStall); end
    checks++; if (HostRDValid !== 1'b0) begin errors++; $display("[TB] FAIL rstburst_rdvalid: got %b want 0", HostRDValid); end
    checks++; if (HostRD !== '0) begin errors++; $display("[TB] FAIL rstburst_hostrd: got %h want 0", HostRD); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (HostGnt !== 1'b0) begin errors++; $display("[TB] FAIL postrst_gnt: got %b want 0", HostGnt); end
    checks++; if (CpuStall !== 1'b0) begin errors++; $display("[TB] FAIL postrst_stall: got %b want 0", CpuStall); end
    checks++; if (MemA !== 32'h10) begin errors++; $display("[TB] FAIL postrst_addr: got %h want 10", MemA); end
    goIdle();
  endtask

  // HostRD captures the address of the grant cycle even if HostA moves afterwards.
  task automatic test_host_read_addr_change();
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, '0, 1'b1, 1'b1, 1'b0, 32'h30, fillVec(8'h11));
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, '0, 1'b1, 1'b1, 1'b0, 32'h31, fillVec(8'h22));
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, '0, 1'b1, 1'b0, 1'b0, 32'h30, '0);
    #1;
    checks++; if (HostGnt !== 1'b1) begin errors++; $display("[TB] FAIL addrchg_gnt: got %b want 1", HostGnt); end
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b0, 32'h31, '0);
    #1;
    checks++; if (HostRDValid !== 1'b1) begin errors++; $display("[TB] FAIL addrchg_valid: got %b want 1", HostRDValid); end
    checks++; if (HostRD !== fillVec(8'h11)) begin errors++; $display("[TB] FAIL addrchg_data: got %h want %h", HostRD, fillVec(8'h11)); end
    goIdle();
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_cpu_store_load();
    test_host_write_read();
    test_starvation();
    test_burst();
    test_reset_mid_burst();
    test_host_read_addr_change();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
